reset_sequencer: RTL and testbench

Orders the release of up to NUM_STAGES reset domains. It provides the power-on hold and the per-domain handshake that a single controlled POR counter cannot.
- All domain resets are held for a fixed hold time after system reset or a soft-reset request.
- Domains are then released one at a time, in index order.
- Each stage must acknowledge through stage_ready before the next stage is released. Typical acknowledges are PLL lock, PHY init done, or a downstream POR done.
- Sits at the top of the clock/reset tree, in the same clock domain as its consumers. It drives the per-domain reset inputs.

---
 rtl/reset_sequencer.sv | 122 ++++++++++++
 tb/tb_reset_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// Holds every reset domain for a fixed time, then releases the domains one at a
// time in index order. Each release waits for that stage's ready acknowledge.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   S_HOLD  | all stages in reset, counting HOLD_CYCLES
//   S_WAIT  | stage k released, waiting for stage_ready[k] (bounded)
//   S_GAP   | stage k acknowledged, idling GAP_CYCLES before releasing k+1
//   S_DONE  | every stage released and acknowledged
//   S_ERROR | stage k never acknowledged; stages k.. held in reset
module reset_sequencer #(
  parameter int NUM_STAGES     = 4,
  parameter int HOLD_CYCLES    = 85,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  localparam int K_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  soft_reset_req,
  input  logic [NUM_STAGES-1:0] stage_ready,
  output logic [NUM_STAGES-1:0] stage_reset,
  output logic                  busy,
  output logic                  all_done,
  output logic                  timeout_err,
  output logic [K_W-1:0]        err_stage
);

  localparam int CNT_MAX_HG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_HG > TIMEOUT_CYCLES) ? CNT_MAX_HG : TIMEOUT_CYCLES;
  localparam int CNT_W      = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [K_W-1:0]   LAST_K    = K_W'(NUM_STAGES - 1);

  typedef enum logic [2:0] {S_HOLD, S_WAIT, S_GAP, S_DONE, S_ERROR} state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [K_W-1:0]          k, k_nxt;
  logic [K_W:0]            rel_nxt;
  logic [NUM_STAGES-1:0]   stage_reset_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    k_nxt     = k;
    case (state)
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
          k_nxt     = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_WAIT: begin
        // Ready wins over a timeout expiring on the same edge.
        if (stage_ready[k]) begin
          cnt_nxt = '0;
          if (k == LAST_K) state_nxt = S_DONE;
          else if (GAP_CYCLES == 0) k_nxt = k + 1'b1;
          else state_nxt = S_GAP;
        end else if (cnt == TO_LAST) begin
          state_nxt = S_ERROR;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_WAIT;
          cnt_nxt   = '0;
          k_nxt     = k + 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Outputs derive from the number of released stages, so they stay thermometer-coded.
  always_comb begin
    case (state_nxt)
      S_HOLD:        rel_nxt = '0;
      S_WAIT, S_GAP: rel_nxt = {1'b0, k_nxt} + 1'b1;
      S_DONE:        rel_nxt = (K_W+1)'(NUM_STAGES);
      default:       rel_nxt = {1'b0, k_nxt};
    endcase
    stage_reset_nxt = '1;
    for (int j = 0; j < NUM_STAGES; j++) begin
      stage_reset_nxt[j] = ((K_W+1)'(j) >= rel_nxt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset || soft_reset_req) begin
      state       <= S_HOLD;
      cnt         <= '0;
      k           <= '0;
      stage_reset <= '1;
      busy        <= 1'b1;
      all_done    <= 1'b0;
      timeout_err <= 1'b0;
      err_stage   <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      k           <= k_nxt;
      stage_reset <= stage_reset_nxt;
      busy        <= (state_nxt != S_DONE) && (state_nxt != S_ERROR);
      all_done    <= (state_nxt == S_DONE);
      timeout_err <= (state_nxt == S_ERROR);
      err_stage   <= (state_nxt == S_ERROR) ? k_nxt : '0;
    end
  end

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: two instances (GAP=4 and GAP=0) share stimulus and
// are checked every cycle against an edge-timestamp model plus literal checkpoints.
module tb_reset_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 85;
  localparam int TO   = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         soft_reset_req;
  logic [N-1:0] stage_ready;

  logic [N-1:0] a_sr[2];
  logic         a_busy[2];
  logic         a_done[2];
  logic         a_terr[2];
  logic [1:0]   a_es[2];

  int n_chk  = 0;
  int n_fail = 0;
  int at     = 0;

  always #5 clk = ~clk;

  reset_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(4), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .stage_ready(stage_ready),
    .stage_reset(a_sr[0]), .busy(a_busy[0]), .all_done(a_done[0]),
    .timeout_err(a_terr[0]), .err_stage(a_es[0])
  );

  reset_sequencer #(.NUM_STAGES(N), .HOLD_CYCLES(HOLD), .GAP_CYCLES(0), .TIMEOUT_CYCLES(TO)) dut_g0 (
    .clk(clk), .reset(reset), .soft_reset_req(soft_reset_req), .stage_ready(stage_ready),
    .stage_reset(a_sr[1]), .busy(a_busy[1]), .all_done(a_done[1]),
    .timeout_err(a_terr[1]), .err_stage(a_es[1])
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: milestones are edge timestamps; a stage releases a fixed number of
  // edges after the previous milestone, or times out TO edges after release.
  int  ecnt = 0;
  bit  mvalid = 0;
  int  m_rel[2], m_start[2], m_rel_edge[2], m_ack[2], m_estage[2];
  bit  m_err[2], m_done[2];

  function automatic int gap_of(input int i);
    return (i == 0) ? 4 : 0;
  endfunction

  always @(posedge clk) begin
    ecnt++;
    for (int i = 0; i < 2; i++) begin
      if (reset || soft_reset_req) begin
        m_rel[i] = 0; m_start[i] = ecnt; m_ack[i] = -1;
        m_err[i] = 0; m_done[i] = 0; m_estage[i] = 0; m_rel_edge[i] = 0;
      end else if (m_err[i] || m_done[i]) begin
      end else if (m_rel[i] == 0) begin
        if (ecnt - m_start[i] == HOLD) begin
          m_rel[i] = 1; m_rel_edge[i] = ecnt;
        end
      end else if (m_ack[i] < 0) begin
        if (stage_ready[m_rel[i]-1]) begin
          if (m_rel[i] == N) m_done[i] = 1;
          else if (gap_of(i) == 0) begin m_rel[i]++; m_rel_edge[i] = ecnt; end
          else m_ack[i] = ecnt;
        end else if (ecnt - m_rel_edge[i] == TO) begin
          m_err[i] = 1; m_estage[i] = m_rel[i] - 1;
        end
      end else if (ecnt - m_ack[i] == gap_of(i)) begin
        m_rel[i]++; m_rel_edge[i] = ecnt; m_ack[i] = -1;
      end
    end
    if (reset) mvalid = 1;
  end

  always @(negedge clk) begin : cmp
    int r;
    logic [N-1:0] esr;
    if (mvalid) begin
      for (int i = 0; i < 2; i++) begin
        r = m_err[i] ? m_rel[i] - 1 : m_rel[i];
        for (int j = 0; j < N; j++) esr[j] = (j >= r);
        chk(i ? "model g0 stage_reset" : "model stage_reset", a_sr[i], esr);
        chk(i ? "model g0 busy" : "model busy", a_busy[i], !(m_err[i] || m_done[i]));
        chk(i ? "model g0 all_done" : "model all_done", a_done[i], m_done[i]);
        chk(i ? "model g0 timeout_err" : "model timeout_err", a_terr[i], m_err[i]);
        chk(i ? "model g0 err_stage" : "model err_stage", a_es[i], m_err[i] ? m_estage[i] : 0);
      end
    end
  end

  task automatic lit(input string nm, input int i, input logic [N-1:0] sr_e,
                     input logic busy_e, input logic done_e, input logic terr_e);
    chk({nm, " stage_reset"}, a_sr[i], sr_e);
    chk({nm, " busy"}, a_busy[i], busy_e);
    chk({nm, " all_done"}, a_done[i], done_e);
    chk({nm, " timeout_err"}, a_terr[i], terr_e);
  endtask

  task automatic adv(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go_to(input int e);
    adv(e - at);
    at = e;
  endtask

  task automatic rst_seq();
    reset = 1'b1;
    adv(5);
    reset = 1'b0;
    at = 0;
  endtask

  task automatic soft_pulse();
    soft_reset_req = 1'b1;
    adv(1);
    soft_reset_req = 1'b0;
    at = 0;
  endtask

  initial begin
    reset = 1'b1; soft_reset_req = 1'b0; stage_ready = '0;
    adv(2);
    lit("reset", 0, 3'b111, 1, 0, 0);
    chk("reset err_stage", a_es[0], 0);
    lit("reset g0", 1, 3'b111, 1, 0, 0);

    // power-up, ready tied high
    stage_ready = 3'b111;
    rst_seq();
    go_to(84); lit("s1 e84", 0, 3'b111, 1, 0, 0); lit("s1 g0 e84", 1, 3'b111, 1, 0, 0);
    go_to(85); lit("s1 e85", 0, 3'b110, 1, 0, 0); lit("s1 g0 e85", 1, 3'b110, 1, 0, 0);
    go_to(86); lit("s1 g0 e86", 1, 3'b100, 1, 0, 0);
    go_to(87); lit("s1 g0 e87", 1, 3'b000, 1, 0, 0);
    go_to(88); lit("s1 g0 e88", 1, 3'b000, 0, 1, 0);
    go_to(90); lit("s1 e90", 0, 3'b100, 1, 0, 0);
    go_to(95); lit("s1 e95", 0, 3'b000, 1, 0, 0);
    go_to(96); lit("s1 e96", 0, 3'b000, 0, 1, 0);
    stage_ready = 3'b000;
    go_to(100); lit("s1 done ignores ready", 0, 3'b000, 0, 1, 0);

    // slow acknowledge of stage 1
    stage_ready = 3'b001;
    rst_seq();
    go_to(90);  lit("s2 e90", 0, 3'b100, 1, 0, 0);
    go_to(110); stage_ready = 3'b011;
    go_to(114); lit("s2 e114", 0, 3'b100, 1, 0, 0);
    go_to(115); lit("s2 e115", 0, 3'b000, 1, 0, 0);
    stage_ready = 3'b111;
    go_to(116); lit("s2 e116", 0, 3'b000, 0, 1, 0);

    // timeout on stage 1, then soft reset replays power-up timing
    stage_ready = 3'b001;
    rst_seq();
    go_to(121); lit("s3 e121", 0, 3'b100, 1, 0, 0);
    go_to(122); lit("s3 e122", 0, 3'b110, 0, 0, 1); chk("s3 err_stage", a_es[0], 1);
    stage_ready = 3'b011;
    go_to(126); lit("s3 late ready", 0, 3'b110, 0, 0, 1);
    lit("s3 g0 error", 1, 3'b110, 0, 0, 1); chk("s3 g0 err_stage", a_es[1], 1);
    stage_ready = 3'b111;
    soft_pulse();
    lit("s3 soft", 0, 3'b111, 1, 0, 0); chk("s3 soft err_stage", a_es[0], 0);
    go_to(84); lit("s3 e84", 0, 3'b111, 1, 0, 0);
    go_to(85); lit("s3 e85", 0, 3'b110, 1, 0, 0);
    go_to(90); lit("s3 e90", 0, 3'b100, 1, 0, 0);
    go_to(95); lit("s3 e95", 0, 3'b000, 1, 0, 0);
    go_to(96); lit("s3 e96", 0, 3'b000, 0, 1, 0);

    // soft reset during GAP after stage 0
    rst_seq();
    go_to(87); lit("s4 gap", 0, 3'b110, 1, 0, 0);
    soft_pulse();
    lit("s4 soft", 0, 3'b111, 1, 0, 0); lit("s4 g0 soft", 1, 3'b111, 1, 0, 0);
    go_to(84); lit("s4 e84", 0, 3'b111, 1, 0, 0);
    go_to(85); lit("s4 e85", 0, 3'b110, 1, 0, 0);

    // ready on the last WAIT edge, then reset+soft together in DONE
    stage_ready = 3'b001;
    rst_seq();
    go_to(121); stage_ready = 3'b011;
    go_to(122); lit("s6 e122", 0, 3'b100, 1, 0, 0);
    go_to(126); lit("s6 e126", 0, 3'b000, 1, 0, 0);
    stage_ready = 3'b111;
    go_to(127); lit("s6 e127", 0, 3'b000, 0, 1, 0);
    reset = 1'b1; soft_reset_req = 1'b1;
    adv(1);
    reset = 1'b0; soft_reset_req = 1'b0; at = 0;
    lit("s6 both", 0, 3'b111, 1, 0, 0); lit("s6 g0 both", 1, 3'b111, 1, 0, 0);
    adv(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
